gps_nav_spreader: RTL and testbench
===================================

Name: gps_nav_spreader

Overview:
- Stage directly downstream of the C/A code generator in the GPS baseband signal generator.
- Consumes the chip stream, chip strobe and chip index, and counts code epochs (20 per nav bit).
- Shifts out 30-bit navigation words MSB first and XORs the current nav bit onto every chip.
- Emits a registered ±1 BPSK baseband sample per chip and flags navigation-data underrun.

Parameters:
CODE_LAST, 1022, index of last chip in a C/A epoch (epoch length 1023)
EPOCHS_PER_BIT, 20, code epochs per navigation bit
WORD_BITS, 30, bits per navigation word

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
chip_stb  in  1  one-cycle strobe; code_in/code_cnt_in valid this cycle
code_in  in  1  current C/A chip
code_cnt_in  in  10  index of chip on code_in, 0..CODE_LAST
word_in  in  30  navigation word, bit 29 = D1, sent first
word_valid  in  1  word_in valid
word_ready  out  1  holding register empty
chip_out  out  1  code_in ^ nav bit
sample_out  out  2  signed sample: 2'b01 (+1) when chip_out=0, 2'b11 (-1) when chip_out=1
sample_vld  out  1  sample_out/chip_out valid
bit_idx  out  5  index of nav bit in flight, 0..29
epoch_idx  out  5  epoch within bit, 0..19
running  out  1  state is RUN
underrun  out  1  sticky: word boundary reached with holding empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst; the polarity and synchronicity are fixed.
- Reset values: word_ready=1 (holding empty); chip_out=0; sample_out=2'b01; sample_vld=0; bit_idx=0; epoch_idx=0; running=0; underrun=0. State is IDLE. Shift and holding registers are 0.
- Handshake: a transfer occurs on word_valid && word_ready and writes the holding register. word_ready is registered, equals ~hold_full, and has no same-cycle bypass.
- Epoch end: chip_stb && code_cnt_in==CODE_LAST.
- States:
  - IDLE: waits for hold_full and then an epoch end. On that epoch end, move holding→shift, clear hold_full, bit_idx=0, epoch_idx=0, go to RUN. Chips arriving in IDLE still produce samples with nav bit 0.
  - RUN: on each epoch end, epoch_idx increments. At 19 it wraps to 0 and bit_idx increments.
    - When bit_idx==29 and epoch_idx==19 (word end): if hold_full, reload shift from holding and clear hold_full, bit_idx=0.
    - Otherwise set underrun, load shift with 0, bit_idx=0, go to UNDERRUN.
  - UNDERRUN: nav bit 0 and counters run as in RUN. At the next word end, a full holding register reloads the shift register and returns to RUN.
  - underrun stays set until reset.
- Nav bit: shift[29]. The shift register shifts left once per bit boundary, so the new bit applies from the first chip of the next epoch.
- Output latency: chip_out, sample_out and sample_vld are registered one cycle after chip_stb. sample_vld is 0 in cycles without chip_stb, and chip_out/sample_out hold their values in those cycles.
- code_cnt_in jumps without reaching CODE_LAST: no epoch end is seen, so counters stall. There is no error flag.
- Reset mid-word: everything returns to reset values and the current word is lost.

Optional Feature:
- Macro: GPS_PARITY_EN.
- Defined:
  - word_in[29:6] carries data bits d1..d24; word_in[5:0] is ignored.
  - On each holding→shift load, IS-GPS-200 parity D25..D30 is computed from D29*/D30* of the previously loaded word; both are 0 after reset.
  - Data bits are inverted when D30*=1.
  - D29*/D30* are updated after every load, including the zero word loaded on underrun.
- Undefined: words are transmitted verbatim with no parity logic.

Decomposition:
- Shared package gps_pkg:
  - constants C_CODE_LAST=1022, C_EPOCHS_PER_BIT=20, C_WORD_BITS=30;
  - state encoding IDLE/RUN/UNDERRUN;
  - sample encodings SAMPLE_POS=2'b01 and SAMPLE_NEG=2'b11.
- One sub-module, gps_nav_parity: combinational parity/inversion of 24 data bits plus D29*/D30* into a 30-bit word. It is instantiated only under GPS_PARITY_EN.

Test Plan:
1. Reset with word_valid=0 → word_ready=1, sample_out=2'b01, running=0. Chips with code 1 → chip_out=1, sample_out=2'b11 one cycle after each chip_stb.
2. Load 30'h2AAAAAAA, then run one epoch → running=1 after the epoch end. The first 20 epochs are inverted relative to code_in (bit 1) and the next 20 are uninverted; bit_idx steps 0→1→2.
3. Two words back-to-back, with the second loaded during word 1 → seamless reload at epoch 600, underrun=0, word_ready rises the cycle after reload.
4. No second word → underrun=1 after epoch 600 and chip_out==code_in. A word written later resumes RUN at the next word end (epoch 1200).
5. Assert rst during bit 15 of a word → all outputs return to reset values immediately, with no clk edge needed.
6. GPS_PARITY_EN, data 24'h8B0000 after reset → transmitted bits 25..30 match the IS-GPS-200 reference model. A following word sees inversion when the previous D30=1.

Source files
------------

// File: rtl/gps_pkg.sv
// rtl/gps_pkg.sv - shared constants, state and sample encodings for the nav spreader
package gps_pkg;

    localparam int C_CODE_LAST      = 1022;
    localparam int C_EPOCHS_PER_BIT = 20;
    localparam int C_WORD_BITS      = 30;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        UNDERRUN = 2'd2
    } nav_state_e;

    localparam logic [1:0] SAMPLE_POS = 2'b01;
    localparam logic [1:0] SAMPLE_NEG = 2'b11;

endpackage

// File: rtl/gps_nav_parity.sv
// rtl/gps_nav_parity.sv - IS-GPS-200 parity and data inversion for one 30-bit nav word
module gps_nav_parity (
    input  logic [23:0] data_in,
    input  logic        d29_star,
    input  logic        d30_star,
    output logic [29:0] word_out
);

    // d[i] is source data bit d_i, with d1 = data_in[23]
    logic [24:1] d;
    logic [5:0]  par;

    always_comb begin
        for (int i = 1; i <= 24; i++) begin
            d[i] = data_in[24-i];
        end
    end

    always_comb begin
        par[5] = d29_star ^ d[1] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[10] ^ d[11] ^ d[12]
                 ^ d[13] ^ d[14] ^ d[17] ^ d[18] ^ d[20] ^ d[23];
        par[4] = d30_star ^ d[2] ^ d[3] ^ d[4] ^ d[6] ^ d[7] ^ d[11] ^ d[12] ^ d[13]
                 ^ d[14] ^ d[15] ^ d[18] ^ d[19] ^ d[21] ^ d[24];
        par[3] = d29_star ^ d[1] ^ d[3] ^ d[4] ^ d[5] ^ d[7] ^ d[8] ^ d[12] ^ d[13]
                 ^ d[14] ^ d[15] ^ d[16] ^ d[19] ^ d[20] ^ d[22];
        par[2] = d30_star ^ d[2] ^ d[4] ^ d[5] ^ d[6] ^ d[8] ^ d[9] ^ d[13] ^ d[14]
                 ^ d[15] ^ d[16] ^ d[17] ^ d[20] ^ d[21] ^ d[23];
        par[1] = d30_star ^ d[1] ^ d[3] ^ d[5] ^ d[6] ^ d[7] ^ d[9] ^ d[10] ^ d[14]
                 ^ d[15] ^ d[16] ^ d[17] ^ d[18] ^ d[21] ^ d[22] ^ d[24];
        par[0] = d29_star ^ d[3] ^ d[5] ^ d[6] ^ d[8] ^ d[9] ^ d[10] ^ d[11] ^ d[13]
                 ^ d[15] ^ d[19] ^ d[22] ^ d[23] ^ d[24];
    end

    assign word_out = {data_in ^ {24{d30_star}}, par};

endmodule

// File: rtl/gps_nav_spreader.sv
// rtl/gps_nav_spreader.sv - nav-bit spreading of the C/A chip stream into BPSK samples
// Optional GPS_PARITY_EN: words carry 24 data bits and gain IS-GPS-200 parity at load.
module gps_nav_spreader
    import gps_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        chip_stb,
    input  logic        code_in,
    input  logic [9:0]  code_cnt_in,
    input  logic [29:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        chip_out,
    output logic [1:0]  sample_out,
    output logic        sample_vld,
    output logic [4:0]  bit_idx,
    output logic [4:0]  epoch_idx,
    output logic        running,
    output logic        underrun
);

    nav_state_e  state_q, state_d;
    logic [29:0] hold_q, hold_d;
    logic [29:0] shift_q, shift_d;
    logic        hold_full_q, hold_full_d;
    logic        word_ready_q, word_ready_d;
    logic [4:0]  bit_q, bit_d;
    logic [4:0]  epoch_q, epoch_d;
    logic        underrun_q, underrun_d;
    logic        chip_q, chip_d;
    logic [1:0]  sample_q, sample_d;
    logic        vld_q, vld_d;
    logic [29:0] load_word;
    logic        load;
    logic        epoch_end;

    assign epoch_end = chip_stb && (code_cnt_in == 10'(C_CODE_LAST));

`ifdef GPS_PARITY_EN
    logic d29s_q, d29s_d;
    logic d30s_q, d30s_d;
    logic unused_low;

    gps_nav_parity u_parity (
        .data_in  (hold_q[29:6]),
        .d29_star (d29s_q),
        .d30_star (d30s_q),
        .word_out (load_word)
    );

    // parity chains across every load, including the zero word of an underrun
    always_comb begin
        d29s_d = d29s_q;
        d30s_d = d30s_q;
        if (load) begin
            d29s_d = shift_d[1];
            d30s_d = shift_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d29s_q <= 1'b0;
            d30s_q <= 1'b0;
        end else begin
            d29s_q <= d29s_d;
            d30s_q <= d30s_d;
        end
    end

    assign unused_low = ^hold_q[5:0];
`else
    logic unused_load;

    assign load_word   = hold_q;
    assign unused_load = load;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            hold_full_q  <= 1'b0;
            word_ready_q <= 1'b1;
            bit_q        <= '0;
            epoch_q      <= '0;
            underrun_q   <= 1'b0;
            chip_q       <= 1'b0;
            sample_q     <= SAMPLE_POS;
            vld_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            hold_full_q  <= hold_full_d;
            word_ready_q <= word_ready_d;
            bit_q        <= bit_d;
            epoch_q      <= epoch_d;
            underrun_q   <= underrun_d;
            chip_q       <= chip_d;
            sample_q     <= sample_d;
            vld_q        <= vld_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        epoch_d     = epoch_q;
        underrun_d  = underrun_q;
        load        = 1'b0;

        // word_ready is only high while holding is empty, so a write never meets a load
        if (word_valid && word_ready_q) begin
            hold_d      = word_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (epoch_end && hold_full_q) begin
                    shift_d     = load_word;
                    hold_full_d = 1'b0;
                    bit_d       = '0;
                    epoch_d     = '0;
                    load        = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN, UNDERRUN: begin
                if (epoch_end) begin
                    if (epoch_q == 5'(C_EPOCHS_PER_BIT - 1)) begin
                        epoch_d = '0;
                        if (bit_q == 5'(C_WORD_BITS - 1)) begin
                            bit_d = '0;
                            load  = 1'b1;
                            if (hold_full_q) begin
                                shift_d     = load_word;
                                hold_full_d = 1'b0;
                                state_d     = RUN;
                            end else begin
                                shift_d    = '0;
                                underrun_d = 1'b1;
                                state_d    = UNDERRUN;
                            end
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shift_d = shift_q << 1;
                        end
                    end else begin
                        epoch_d = epoch_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        word_ready_d = ~hold_full_d;
    end

    always_comb begin
        chip_d   = chip_q;
        sample_d = sample_q;
        vld_d    = chip_stb;
        if (chip_stb) begin
            chip_d   = code_in ^ shift_q[C_WORD_BITS-1];
            sample_d = chip_d ? SAMPLE_NEG : SAMPLE_POS;
        end
    end

    always_comb begin
        word_ready = word_ready_q;
        chip_out   = chip_q;
        sample_out = sample_q;
        sample_vld = vld_q;
        bit_idx    = bit_q;
        epoch_idx  = epoch_q;
        running    = (state_q == RUN);
        underrun   = underrun_q;
    end

endmodule

// File: tb/tb_gps_nav_spreader.sv
// tb/tb_gps_nav_spreader.sv - directed self-checking bench for gps_nav_spreader
module tb_gps_nav_spreader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        chip_stb = 1'b0;
    logic        code_in = 1'b0;
    logic [9:0]  code_cnt_in = '0;
    logic [29:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        chip_out;
    logic [1:0]  sample_out;
    logic        sample_vld;
    logic [4:0]  bit_idx;
    logic [4:0]  epoch_idx;
    logic        running;
    logic        underrun;

    int n_checks = 0;
    int n_fail   = 0;

    gps_nav_spreader dut (
        .clk         (clk),
        .rst         (rst),
        .chip_stb    (chip_stb),
        .code_in     (code_in),
        .code_cnt_in (code_cnt_in),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .chip_out    (chip_out),
        .sample_out  (sample_out),
        .sample_vld  (sample_vld),
        .bit_idx     (bit_idx),
        .epoch_idx   (epoch_idx),
        .running     (running),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chip(input logic c, input logic [9:0] cnt);
        chip_stb    = 1'b1;
        code_in     = c;
        code_cnt_in = cnt;
        tick();
        chip_stb    = 1'b0;
    endtask

    task automatic epochs(input int n, input logic c);
        for (int i = 0; i < n; i++) chip(c, 10'd1022);
    endtask

    task automatic write_word(input logic [29:0] w);
        int guard;
        guard = 0;
        while (!word_ready && guard < 2000) begin
            tick();
            guard++;
        end
        check_eq("write_ready", 32'(word_ready), 32'd1);
        word_in    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},    32'(word_ready), 32'd1);
        check_eq({tag, "_chip"},     32'(chip_out),   32'd0);
        check_eq({tag, "_sample"},   32'(sample_out), 32'h1);
        check_eq({tag, "_vld"},      32'(sample_vld), 32'd0);
        check_eq({tag, "_bit"},      32'(bit_idx),    32'd0);
        check_eq({tag, "_epoch"},    32'(epoch_idx),  32'd0);
        check_eq({tag, "_running"},  32'(running),    32'd0);
        check_eq({tag, "_underrun"}, 32'(underrun),   32'd0);
    endtask

`ifdef GPS_PARITY_EN
    // one chip_out sample at the first epoch of each nav bit, code held at 0
    task automatic capture_word(output logic [29:0] w);
        w = '0;
        for (int b = 0; b < 30; b++) begin
            for (int e = 0; e < 20; e++) begin
                chip(1'b0, 10'd1022);
                if (e == 0) w[29-b] = chip_out;
            end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef GPS_PARITY_EN
        logic [29:0] cap;
`endif
        repeat (2) tick();
        check_reset_outputs("in_reset");
        rst = 1'b1;
        tick();
        check_reset_outputs("after_reset");

        // IDLE chips pass code straight through
        chip(1'b1, 10'd5);
        check_eq("idle_chip", 32'(chip_out), 32'd1);
        check_eq("idle_sample", 32'(sample_out), 32'h3);
        check_eq("idle_vld", 32'(sample_vld), 32'd1);
        tick();
        check_eq("gap_vld", 32'(sample_vld), 32'd0);
        check_eq("gap_chip_hold", 32'(chip_out), 32'd1);
        check_eq("gap_sample_hold", 32'(sample_out), 32'h3);

`ifndef GPS_PARITY_EN
        write_word(30'h2AAAAAAA);
        check_eq("t2_ready_low", 32'(word_ready), 32'd0);
        check_eq("t2_not_running", 32'(running), 32'd0);
        chip(1'b1, 10'd1022);
        check_eq("t2_running", 32'(running), 32'd1);
        check_eq("t2_start_chip", 32'(chip_out), 32'd1);
        check_eq("t2_ready_back", 32'(word_ready), 32'd1);
        check_eq("t2_bit0", 32'(bit_idx), 32'd0);
        chip(1'b1, 10'd100);
        check_eq("t2_inv_chip", 32'(chip_out), 32'd0);
        check_eq("t2_inv_sample", 32'(sample_out), 32'h1);
        epochs(19, 1'b1);
        check_eq("t2_epoch19", 32'(epoch_idx), 32'd19);
        check_eq("t2_inv_last", 32'(chip_out), 32'd0);
        epochs(1, 1'b1);
        check_eq("t2_bit1", 32'(bit_idx), 32'd1);
        check_eq("t2_epoch_wrap", 32'(epoch_idx), 32'd0);
        check_eq("t2_edge_chip_old_bit", 32'(chip_out), 32'd0);
        chip(1'b1, 10'd3);
        check_eq("t2_uninv_chip", 32'(chip_out), 32'd1);
        epochs(20, 1'b1);
        check_eq("t2_bit2", 32'(bit_idx), 32'd2);

        // second word queued during word 1: seamless reload at epoch 600
        write_word(30'h20000000);
        check_eq("t3_ready_low", 32'(word_ready), 32'd0);
        epochs(559, 1'b0);
        check_eq("t3_bit29", 32'(bit_idx), 32'd29);
        check_eq("t3_epoch19", 32'(epoch_idx), 32'd19);
        epochs(1, 1'b0);
        check_eq("t3_reload_bit", 32'(bit_idx), 32'd0);
        check_eq("t3_reload_epoch", 32'(epoch_idx), 32'd0);
        check_eq("t3_no_underrun", 32'(underrun), 32'd0);
        check_eq("t3_running", 32'(running), 32'd1);
        check_eq("t3_ready_after", 32'(word_ready), 32'd1);
        chip(1'b0, 10'd7);
        check_eq("t3_word2_bit", 32'(chip_out), 32'd1);

        // no third word: underrun at the next word end, then recovery one word later
        epochs(599, 1'b0);
        check_eq("t4_pre_bit29", 32'(bit_idx), 32'd29);
        check_eq("t4_pre_underrun", 32'(underrun), 32'd0);
        epochs(1, 1'b0);
        check_eq("t4_underrun", 32'(underrun), 32'd1);
        check_eq("t4_not_running", 32'(running), 32'd0);
        check_eq("t4_bit0", 32'(bit_idx), 32'd0);
        chip(1'b1, 10'd8);
        check_eq("t4_passthru", 32'(chip_out), 32'd1);
        write_word(30'h20000000);
        epochs(599, 1'b1);
        check_eq("t4_still_under", 32'(running), 32'd0);
        epochs(1, 1'b1);
        check_eq("t4_resume", 32'(running), 32'd1);
        check_eq("t4_sticky", 32'(underrun), 32'd1);
        check_eq("t4_ready", 32'(word_ready), 32'd1);
        chip(1'b0, 10'd9);
        check_eq("t4_word3_bit", 32'(chip_out), 32'd1);

        // asynchronous reset during bit 15
        epochs(305, 1'b0);
        check_eq("t5_bit15", 32'(bit_idx), 32'd15);
        chip(1'b1, 10'd11);
        check_eq("t5_chip_pre", 32'(chip_out), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("t5_idle_after", 32'(running), 32'd0);
`else
        write_word({24'h8B0000, 6'h15});
        chip(1'b0, 10'd1022);
        check_eq("t6_running", 32'(running), 32'd1);
        write_word({24'h000000, 6'h2A});
        capture_word(cap);
        check_eq("t6_word1", 32'(cap), 32'h22C00012);
        write_word({24'h8B0000, 6'h00});
        capture_word(cap);
        check_eq("t6_word2", 32'(cap), 32'h00000029);
        capture_word(cap);
        check_eq("t6_word3_inverted", 32'(cap), 32'h1D3FFFC4);
        check_eq("t6_no_underrun", 32'(underrun), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
